// File: rtl/answer_judge.sv
// -----------------------------------------------------------------------------
// answer_judge
//
// Game controller that sits between question_show and the score / seven-segment
// displays. For every question it latches the operands, works out the correct
// answer, watches both 9-button joysticks for new presses, judges the first
// answers, keeps both scores and pulses next_q so state_counter moves on to the
// next question. The game stops after NUM_QUESTIONS questions.
//
// Ports
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high
//   start        in   1  level; starts a game from IDLE or DONE
//   num_left     in   4  left operand
//   num_right    in   4  right operand
//   operater     in   4  one-hot op: 1000 div, 0100 mul, 0010 sub, 0001 add
//   joy_left     in   9  left player buttons, bit k = answer k+1 (asynchronous)
//   joy_right    in   9  right player buttons, same encoding
//   score_left   out  5  left player score
//   score_right  out  5  right player score
//   next_q       out  1  one-cycle pulse: advance to the next question
//   q_index      out  4  current question number, 0-based
//   show_answer  out  4  correct answer while it is shown, else 0
//   busy         out  1  high while a question is in progress
//   game_over    out  1  high once all questions have been played
// -----------------------------------------------------------------------------
module answer_judge #(
    parameter int NUM_QUESTIONS  = 9,
    parameter int SHOW_CYCLES    = 50,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SCORE_MAX      = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] num_left,
    input  logic [3:0] num_right,
    input  logic [3:0] operater,
    input  logic [8:0] joy_left,
    input  logic [8:0] joy_right,
    output logic [4:0] score_left,
    output logic [4:0] score_right,
    output logic       next_q,
    output logic [3:0] q_index,
    output logic [3:0] show_answer,
    output logic       busy,
    output logic       game_over
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SHOW_LAST  = SW'(SHOW_CYCLES - 1);
    localparam logic [3:0]    LAST_Q     = 4'(NUM_QUESTIONS - 1);
    localparam logic [4:0]    SCORE_TOP  = 5'(SCORE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ASK,
        JUDGE,
        SHOW,
        DONE
    } state_t;

    state_t state, state_n;

    // Joystick synchronisers and "bus was pressed last cycle" flags.
    logic [8:0] sync1_left, sync2_left, sync1_right, sync2_right;
    logic       any_d_left, any_d_right;

    logic [3:0]    answer, answer_n;
    logic [TW-1:0] timer, timer_n;
    logic [SW-1:0] show_cnt, show_cnt_n;
    logic          lock_left, lock_left_n, lock_right, lock_right_n;
    logic [8:0]    cap_left, cap_left_n, cap_right, cap_right_n;
    logic [4:0]    score_left_n, score_right_n;
    logic [3:0]    q_index_n;
    logic          next_q_n;
    logic          busy_n;

    logic [7:0] result;
    logic       result_ok;
    logic [3:0] answer_calc;

    logic event_left, event_right;
    logic take_left, take_right;
    logic ok_left, ok_right;

    // A press is correct only when exactly the one button matching the
    // answer is down; an unanswerable question (answer 0) never matches.
    function automatic logic is_correct(input logic [8:0] press, input logic [3:0] ans);
        return (ans != 4'd0) && (press == (9'd1 << (ans - 4'd1)));
    endfunction

    // Correct answer for the operands currently on the inputs; 0 means the
    // question cannot be answered with one of the nine buttons.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        result    = '0;
        result_ok = 1'b0;
        case (operater)
            4'b0001: begin
                result    = {4'd0, num_left} + {4'd0, num_right};
                result_ok = 1'b1;
            end
            4'b0010: begin
                if (num_left >= num_right) begin
                    result    = {4'd0, num_left - num_right};
                    result_ok = 1'b1;
                end
            end
            4'b0100: begin
                result    = {4'd0, num_left} * {4'd0, num_right};
                result_ok = 1'b1;
            end
            4'b1000: begin
                if (num_right != 4'd0 && (num_left % num_right) == 4'd0) begin
                    result    = {4'd0, num_left / num_right};
                    result_ok = 1'b1;
                end
            end
            default: ;
        endcase
        answer_calc = (result_ok && result >= 8'd1 && result <= 8'd9) ? result[3:0] : 4'd0;
    end

    // Press event: bus goes from all-released to anything-pressed.
    assign event_left  = (|sync2_left)  && !any_d_left;
    assign event_right = (|sync2_right) && !any_d_right;
    assign take_left   = event_left  && !lock_left;
    assign take_right  = event_right && !lock_right;
    assign ok_left     = is_correct(cap_left,  answer);
    assign ok_right    = is_correct(cap_right, answer);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_left  <= '0;
            sync2_left  <= '0;
            sync1_right <= '0;
            sync2_right <= '0;
            any_d_left  <= 1'b0;
            any_d_right <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each flop samples the value
            // its predecessor held before this edge, giving a true 2-flop chain.
            sync1_left  <= joy_left;
            sync2_left  <= sync1_left;
            sync1_right <= joy_right;
            sync2_right <= sync1_right;
            any_d_left  <= |sync2_left;
            any_d_right <= |sync2_right;
        end
    end

    always_comb begin
        state_n       = state;
        answer_n      = answer;
        timer_n       = timer;
        show_cnt_n    = show_cnt;
        lock_left_n   = lock_left;
        lock_right_n  = lock_right;
        cap_left_n    = cap_left;
        cap_right_n   = cap_right;
        score_left_n  = score_left;
        score_right_n = score_right;
        q_index_n     = q_index;
        next_q_n      = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n       = LOAD;
                    score_left_n  = '0;
                    score_right_n = '0;
                    q_index_n     = '0;
                end
            end

            LOAD: begin
                answer_n     = answer_calc;
                timer_n      = '0;
                lock_left_n  = 1'b0;
                lock_right_n = 1'b0;
                state_n      = ASK;
            end

            ASK: begin
                // Timer holds at its last value so an event arriving on the
                // final cycle still times out on the next ASK cycle.
                if (timer != TIMER_LAST) begin
                    timer_n = timer + 1'b1;
                end
                if (take_left || take_right) begin
                    cap_left_n  = take_left  ? sync2_left  : '0;
                    cap_right_n = take_right ? sync2_right : '0;
                    state_n     = JUDGE;
                end else if (timer == TIMER_LAST) begin
                    show_cnt_n = '0;
                    state_n    = SHOW;
                end
            end

            JUDGE: begin
                if (ok_left || ok_right) begin
                    if (ok_left && score_left < SCORE_TOP) begin
                        score_left_n = score_left + 5'd1;
                    end
                    if (ok_right && score_right < SCORE_TOP) begin
                        score_right_n = score_right + 5'd1;
                    end
                    show_cnt_n = '0;
                    state_n    = SHOW;
                end else begin
                    // No one was right, so any captured press was wrong.
                    lock_left_n  = lock_left  | (|cap_left);
                    lock_right_n = lock_right | (|cap_right);
                    if (lock_left_n && lock_right_n) begin
                        show_cnt_n = '0;
                        state_n    = SHOW;
                    end else begin
                        state_n = ASK;
                    end
                end
            end

            SHOW: begin
                if (show_cnt == SHOW_LAST) begin
                    next_q_n  = 1'b1;
                    q_index_n = q_index + 4'd1;
                    state_n   = (q_index == LAST_Q) ? DONE : LOAD;
                end else begin
                    show_cnt_n = show_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase

        busy_n = (state_n == LOAD) || (state_n == ASK) || (state_n == JUDGE) || (state_n == SHOW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            answer      <= '0;
            timer       <= '0;
            show_cnt    <= '0;
            lock_left   <= 1'b0;
            lock_right  <= 1'b0;
            cap_left    <= '0;
            cap_right   <= '0;
            score_left  <= '0;
            score_right <= '0;
            q_index     <= '0;
            next_q      <= 1'b0;
            show_answer <= '0;
            busy        <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_n;
            answer      <= answer_n;
            timer       <= timer_n;
            show_cnt    <= show_cnt_n;
            lock_left   <= lock_left_n;
            lock_right  <= lock_right_n;
            cap_left    <= cap_left_n;
            cap_right   <= cap_right_n;
            score_left  <= score_left_n;
            score_right <= score_right_n;
            q_index     <= q_index_n;
            next_q      <= next_q_n;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            show_answer <= (state_n == SHOW) ? answer_n : 4'd0;
            busy        <= busy_n;
            game_over   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_answer_judge.sv
// -----------------------------------------------------------------------------
// tb_answer_judge
//
// Self-checking bench for answer_judge. A reference model computes answers
// with plain integer arithmetic and plays each question by the game rules
// (lockouts, saturation, timeout) to predict scores, show_answer, q_index and
// the cycle on which next_q fires. Stimulus mixes directed questions with
// $urandom-generated questions and press sequences.
// -----------------------------------------------------------------------------
module tb_answer_judge;

    localparam int NQ = 9;
    localparam int SC = 6;
    localparam int TO = 60;
    localparam int SM = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_left, num_right, operater;
    logic [8:0] joy_left, joy_right;
    logic [4:0] score_left, score_right;
    logic       next_q;
    logic [3:0] q_index, show_answer;
    logic       busy, game_over;

    answer_judge #(
        .NUM_QUESTIONS (NQ),
        .SHOW_CYCLES   (SC),
        .TIMEOUT_CYCLES(TO),
        .SCORE_MAX     (SM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_left   (num_left),
        .num_right  (num_right),
        .operater   (operater),
        .joy_left   (joy_left),
        .joy_right  (joy_right),
        .score_left (score_left),
        .score_right(score_right),
        .next_q     (next_q),
        .q_index    (q_index),
        .show_answer(show_answer),
        .busy       (busy),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model scores.
    int m_sl = 0;
    int m_sr = 0;

    typedef struct packed {
        logic [3:0]      l;
        logic [3:0]      r;
        logic [3:0]      op;
        logic [2:0]      n;
        logic [3:0][8:0] al;
        logic [3:0][8:0] ar;
        logic            keep_left;
    } q_t;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int ref_answer(input int l, input int r, input int op);
        int v;
        v = -1;
        case (op)
            1: v = l + r;
            2: v = l - r;
            4: v = l * r;
            8: if (r != 0 && (l % r) == 0) v = l / r;
            default: v = -1;
        endcase
        return (v >= 1 && v <= 9) ? v : 0;
    endfunction

    function automatic logic [8:0] onehot(input int k);
        logic [8:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic bit ref_correct(input logic [8:0] v, input int ans);
        if (ans == 0) return 1'b0;
        return ($countones(v) == 1) && v[ans-1];
    endfunction

    function automatic logic [8:0] rand_press(input int ans);
        int kind, b1, b2;
        kind = $urandom_range(0, 3);
        b1   = $urandom_range(0, 8);
        b2   = (b1 + 1 + $urandom_range(0, 7)) % 9;
        case (kind)
            0: return '0;
            1: return (ans != 0) ? onehot(ans - 1) : onehot(b1);
            2: return onehot(b1);
            default: return onehot(b1) | onehot(b2);
        endcase
    endfunction

    // mode 1: always answerable, left player answers correctly.
    function automatic q_t gen_q(input int mode);
        q_t x;
        int ans, l, r, op, kind, sel;
        x = '0;
        if (mode == 1 || $urandom_range(0, 1) == 1) begin
            ans  = $urandom_range(1, 9);
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin l = $urandom_range(0, ans); r = ans - l; op = 1; end
                1: begin r = $urandom_range(0, 15 - ans); l = ans + r; op = 2; end
                2: begin
                    if ($urandom_range(0, 1) == 1) begin l = ans; r = 1; end
                    else begin l = 1; r = ans; end
                    op = 4;
                end
                default: begin r = $urandom_range(1, 15 / ans); l = ans * r; op = 8; end
            endcase
        end else begin
            do begin
                l   = $urandom_range(0, 15);
                r   = $urandom_range(0, 15);
                sel = $urandom_range(0, 4);
                op  = (sel < 4) ? (1 << sel) : $urandom_range(0, 15);
            end while (op == 4 && l * r >= 128 && (l * r) % 128 >= 1 && (l * r) % 128 <= 9);
        end
        x.l  = 4'(l);
        x.r  = 4'(r);
        x.op = 4'(op);
        ans  = ref_answer(l, r, op);
        if (mode == 1) begin
            x.n     = 3'd1;
            x.al[0] = onehot(ans - 1);
            x.ar[0] = ($urandom_range(0, 1) == 1) ? onehot($urandom_range(0, 8)) : 9'd0;
        end else begin
            x.n = 3'($urandom_range(0, 3));
            for (int a = 0; a < 4; a++) begin
                x.al[a] = rand_press(ans);
                x.ar[a] = rand_press(ans);
            end
        end
        return x;
    endfunction

    // Called on the falling edge inside the LOAD cycle of question q.
    task automatic run_question(input int q, input q_t qs);
        int  c0, ans, nj, show_c, osl, osr, last_sa, k;
        bit  ended, ll, lr, okl, okr;
        logic [8:0] el, er;

        num_left  = qs.l;
        num_right = qs.r;
        operater  = qs.op;
        c0     = cyc;
        ans    = ref_answer(int'(qs.l), int'(qs.r), int'(qs.op));
        ended  = 1'b0;
        nj     = 0;
        ll     = 1'b0;
        lr     = 1'b0;
        show_c = 0;
        check("busy_in_load", int'(busy), 1);
        if (q == 2) start = 1'b1;   // must be ignored while busy

        for (int a = 0; a < int'(qs.n) && !ended; a++) begin
            @(negedge clk);
            if (a == 0) check("next_q_one_cycle", int'(next_q), 0);
            joy_left  = qs.al[a];
            joy_right = qs.ar[a];
            el  = ll ? 9'd0 : qs.al[a];
            er  = lr ? 9'd0 : qs.ar[a];
            okl = ref_correct(el, ans);
            okr = ref_correct(er, ans);
            osl = m_sl;
            osr = m_sr;
            if (el != 0 || er != 0) begin
                nj++;
                if (okl || okr) begin
                    if (okl && m_sl < SM) m_sl++;
                    if (okr && m_sr < SM) m_sr++;
                    ended = 1'b1;
                end else begin
                    if (el != 0) ll = 1'b1;
                    if (er != 0) lr = 1'b1;
                    if (ll && lr) ended = 1'b1;
                end
            end
            step(3);
            check("score_left_before_judge", int'(score_left), osl);
            check("score_right_before_judge", int'(score_right), osr);
            step(1);
            check("score_left", int'(score_left), m_sl);
            check("score_right", int'(score_right), m_sr);
            if (ended) begin
                check("show_answer_first", int'(show_answer), ans);
                show_c = cyc;
            end
            joy_right = '0;
            if (!(qs.keep_left && a == int'(qs.n) - 1)) joy_left = '0;
            if (!ended) step(3);
        end
        start = 1'b0;

        last_sa = -1;
        for (k = 0; k < TO + SC + 40; k++) begin
            @(negedge clk);
            if (next_q) break;
            last_sa = int'(show_answer);
        end
        if (k == TO + SC + 40) begin
            check("next_q_seen", 0, 1);
        end else begin
            if (ended) check("show_length", cyc - show_c, SC);
            else       check("timeout_length", cyc - c0, TO + nj + SC + 1);
            check("show_answer_last", last_sa, ans);
            check("show_answer_cleared", int'(show_answer), 0);
            check("q_index", int'(q_index), q + 1);
            check("score_left_end", int'(score_left), m_sl);
            check("score_right_end", int'(score_right), m_sr);
        end
        if (!qs.keep_left) joy_left = '0;
    endtask

    task automatic start_game();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_sl = 0;
        m_sr = 0;
        check("start_score_left", int'(score_left), 0);
        check("start_score_right", int'(score_right), 0);
        check("start_q_index", int'(q_index), 0);
        check("start_game_over", int'(game_over), 0);
    endtask

    task automatic finish_game();
        step(1);
        check("done_next_q_low", int'(next_q), 0);
        check("done_game_over", int'(game_over), 1);
        check("done_busy", int'(busy), 0);
        check("done_q_index", int'(q_index), NQ);
        check("done_score_left", int'(score_left), m_sl);
        check("done_score_right", int'(score_right), m_sr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        q_t qs[NQ];
        int cnt;

        reset     = 1'b0;
        start     = 1'b0;
        num_left  = '0;
        num_right = '0;
        operater  = '0;
        joy_left  = '0;
        joy_right = '0;
        #2 reset = 1'b1;
        step(3);
        check("reset_score_left", int'(score_left), 0);
        check("reset_score_right", int'(score_right), 0);
        check("reset_next_q", int'(next_q), 0);
        check("reset_q_index", int'(q_index), 0);
        check("reset_show_answer", int'(show_answer), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_game_over", int'(game_over), 0);
        reset = 1'b0;
        step(4);
        check("idle_busy", int'(busy), 0);

        // Game 1: directed questions then random ones.
        for (int i = 0; i < NQ; i++) qs[i] = gen_q(0);
        qs[0] = '0; qs[0].l = 4'd8; qs[0].r = 4'd2; qs[0].op = 4'b1000;
        qs[0].n = 3'd1; qs[0].al[0] = onehot(3);
        qs[1] = '0; qs[1].l = 4'd2; qs[1].r = 4'd3; qs[1].op = 4'b0100; qs[1].n = 3'd3;
        qs[1].ar[0] = onehot(4); qs[1].ar[1] = onehot(5); qs[1].al[2] = onehot(5);
        qs[2] = '0; qs[2].l = 4'd5; qs[2].r = 4'd3; qs[2].op = 4'b0001; qs[2].n = 3'd1;
        qs[2].al[0] = onehot(7); qs[2].ar[0] = onehot(7);
        qs[3] = '0; qs[3].l = 4'd7; qs[3].r = 4'd2; qs[3].op = 4'b1000; qs[3].n = 3'd1;
        qs[3].al[0] = onehot(0); qs[3].keep_left = 1'b1;
        qs[4] = '0; qs[4].l = 4'd1; qs[4].r = 4'd0; qs[4].op = 4'b0001; qs[4].n = 3'd0;
        start_game();
        for (int q = 0; q < NQ; q++) run_question(q, qs[q]);
        finish_game();

        // Game 2: left answers the first questions correctly to reach saturation.
        for (int i = 0; i < NQ; i++) qs[i] = gen_q((i < 7) ? 1 : 0);
        start_game();
        for (int q = 0; q < NQ; q++) run_question(q, qs[q]);
        finish_game();

        // Game 3: reset while the answer is being shown.
        start_game();
        num_left  = 4'd8;
        num_right = 4'd2;
        operater  = 4'b1000;
        @(negedge clk);
        joy_left = onehot(3);
        step(4);
        check("g3_score_left", int'(score_left), 1);
        check("g3_show_answer", int'(show_answer), 4);
        step(2);
        reset = 1'b1;
        #1;
        check("rst_score_left", int'(score_left), 0);
        check("rst_score_right", int'(score_right), 0);
        check("rst_next_q", int'(next_q), 0);
        check("rst_q_index", int'(q_index), 0);
        check("rst_show_answer", int'(show_answer), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_game_over", int'(game_over), 0);
        joy_left = '0;
        step(2);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < SC + 6; i++) begin
            @(negedge clk);
            if (next_q) cnt++;
        end
        check("rst_no_next_q", cnt, 0);
        check("rst_idle_busy", int'(busy), 0);

        start_game();
        run_question(0, gen_q(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
